seg7_bcd_reader: RTL
====================

# seg7_bcd_reader

Receives a stream of 7-segment display patterns and converts them back into packed BCD digits, performing the inverse of the team's BCD-to-segment decoders. Patterns arrive one digit per beat, most-significant digit first, over a valid/ready handshake and are accumulated into a multi-digit frame. Each completed frame is presented on an output handshake with a digit count and error flags. The block sits between a segment-pattern source (display-bus monitor or loopback tap) and downstream BCD consumers/checkers.

## Interface
Parameters:
- DIGITS, 4, maximum digits per frame (1..8); output width 4*DIGITS
- CW, $clog2(DIGITS+1), width of digit-count field (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seg_valid  in  1  input beat valid
- seg_ready  out  1  block can accept a beat
- seg_data  in  7  segment pattern, bit0=a … bit6=g, active-high (segment lit = 1)
- seg_last  in  1  beat is final digit of frame
- bcd_valid  out  1  frame result valid
- bcd_ready  in  1  consumer accepts result
- bcd_data  out  4*DIGITS  packed BCD, first-received digit in most-significant occupied nibble, right-aligned
- bcd_count  out  CW  number of digits stored (0..DIGITS)
- bcd_err  out  2  bit0 = invalid pattern seen, bit1 = overflow (more than DIGITS beats)

## Operation
- Pattern map (seg_data hex → digit): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Any other pattern is invalid: nibble F stored, err[0] set sticky for the frame.
- States: COLLECT, HOLD.
- COLLECT: seg_ready=1. On accepted beat (seg_valid & seg_ready): if count<DIGITS, data = {data[4*DIGITS-5:0], nibble}, count++; else beat discarded, err[1] set. If seg_last on accepted beat → HOLD.
- HOLD: seg_ready=0, bcd_valid=1; bcd_data/count/err stable. On bcd_ready → clear data, count, err to 0; → COLLECT.
- Frames with only one beat (seg_last on first beat) are legal; count=1.
- Invalid and overflow errors may coexist; invalid patterns on discarded (overflow) beats do not set err[0].
- No timeout: partial frame waits indefinitely for seg_last.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): state=COLLECT, seg_ready=1, bcd_valid=0, bcd_data=0, bcd_count=0, bcd_err=0.
- Reset mid-frame or in HOLD discards all partial/pending data immediately.
- Latency: bcd_valid rises the cycle after the seg_last beat is accepted.
- seg_ready and bcd_valid are decoded from registered state only (no combinational path from seg_valid or bcd_ready).
- Result handshake completes when bcd_valid & bcd_ready; seg_ready returns high the next cycle, so minimum frame spacing = frame length + 1 cycles for the first beat of the next frame.
- bcd_valid never drops without bcd_ready; outputs do not change while bcd_valid=1.

## Structure
- Shared package: segment-pattern constants SEG_0..SEG_9, BCD_INVALID (4'hF), error-bit indices, state enum.
- Sub-module seg7_to_bcd: purely combinational pattern → {valid, nibble} lookup; top holds FSM, shift register, counter, error flags.

## Test plan
- Beats 06,5B,4F,66 (last on 66), DIGITS=4 → bcd_data=0x1234, count=4, err=00, bcd_valid one cycle after last.
- Beats 7F,6F(last) → bcd_data=0x0089, count=2, err=00.
- Beats 3F,49,07(last) → bcd_data=0x0F7, count=3, err=01.
- Six beats 06,06,06,06,5B,5B(last) → bcd_data=0x1111, count=4, err=10.
- Hold bcd_ready=0 for 10 cycles while source keeps seg_valid=1 → seg_ready=0, outputs stable; on bcd_ready pulse next frame accepted, values cleared.
- Assert rst_n=0 after two beats of a frame → all outputs zero immediately, following frame 66(last) gives 0x0004, count=1.

Source files
------------

// File: rtl/seg7_bcd_reader_pkg.sv
// Shared definitions for the segment-pattern to BCD reader: segment
// encodings (bit0=a .. bit6=g, active-high), error bit positions and FSM states.
package seg7_bcd_reader_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Nibble stored in place of a digit whose pattern is not recognised.
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Positions inside the 2-bit error field.
  localparam int unsigned ERR_INVALID  = 0;
  localparam int unsigned ERR_OVERFLOW = 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_bcd_reader_to_bcd.sv
// Combinational lookup from a 7-segment pattern to a BCD nibble; patterns
// outside the 0..9 set report valid=0 with the invalid nibble.
module seg7_to_bcd
  import seg7_bcd_reader_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  // Exact-match decode of the ten legal digit patterns.
  always_comb begin
    valid  = 1'b1;
    nibble = BCD_INVALID;
    case (seg)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: begin
        valid  = 1'b0;
        nibble = BCD_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/seg7_bcd_reader.sv
// Accumulates a stream of 7-segment patterns (MSD first) into a packed,
// right-aligned BCD frame and offers it on a valid/ready result handshake.
module seg7_bcd_reader
  import seg7_bcd_reader_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  input  logic [6:0]            seg_data,
  input  logic                  seg_last,
  output logic                  bcd_valid,
  input  logic                  bcd_ready,
  output logic [4*DIGITS-1:0]   bcd_data,
  output logic [CW-1:0]         bcd_count,
  output logic [1:0]            bcd_err
);

  state_t              state;
  logic [4*DIGITS-1:0] data_q;
  logic [CW-1:0]       count_q;
  logic [1:0]          err_q;

  logic                pat_valid;
  logic [3:0]          pat_nibble;
  logic                accept;
  logic                room;
  logic [4*DIGITS-1:0] shifted;

  seg7_to_bcd u_dec (
    .seg    (seg_data),
    .valid  (pat_valid),
    .nibble (pat_nibble)
  );

  // Beat acceptance, free-slot test and next shift-register value.
  // The shift is written as shift-then-overwrite so DIGITS=1 needs no special case.
  always_comb begin
    accept       = seg_valid && (state == COLLECT);
    room         = (count_q < CW'(DIGITS));
    shifted      = data_q << 4;
    shifted[3:0] = pat_nibble;
  end

  // Frame FSM with digit shift register, counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (room) begin
              data_q  <= shifted;
              count_q <= count_q + 1'b1;
              if (!pat_valid) err_q[ERR_INVALID] <= 1'b1;
            end else begin
              err_q[ERR_OVERFLOW] <= 1'b1;
            end
            if (seg_last) state <= HOLD;
          end
        end
        HOLD: begin
          if (bcd_ready) begin
            data_q  <= '0;
            count_q <= '0;
            err_q   <= '0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Handshake flags come from the state register only; result fields are the held registers.
  always_comb begin
    seg_ready = (state == COLLECT);
    bcd_valid = (state == HOLD);
    bcd_data  = data_q;
    bcd_count = count_q;
    bcd_err   = err_q;
  end

endmodule
